if_fetch_ctrl: RTL

//  Fetch-stage controller that sits directly upstream of the 32-bit PC register.

---
 rtl/if_fetch_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch-stage controller that sits in front of the PC register.
// It drives npc into the register's d input and reads pc back from its q output.
// It runs the instruction-memory req/ack handshake, buffers one fetched word
// for decode, and handles redirects, including one that lands mid-fetch.
// Optional feature: define EXC_REDIRECT_EN to add exc_req, an exception
// redirect to EXC_VECTOR that takes priority over redirect.
module if_fetch_ctrl #(
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        id_ready,
`ifdef EXC_REDIRECT_EN
    input  logic        exc_req,
`endif
    input  logic        redirect,
    input  logic [31:0] redirect_tgt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;

    // Effective redirect request and its word-aligned target.
    logic        redir;
    logic [31:0] redir_tgt;

`ifdef EXC_REDIRECT_EN
    // An exception overrides a same-cycle branch/jump redirect.
    always_comb begin
        redir     = exc_req | redirect;
        redir_tgt = exc_req ? EXC_VECTOR : redirect_tgt;
        redir_tgt[1:0] = 2'b00;
    end
`else
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;

    // Only branch/jump redirects exist in this build.
    always_comb begin
        redir     = redirect;
        redir_tgt = {redirect_tgt[31:2], 2'b00};
    end
`endif

    // State, buffered instruction and drain address registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            drain_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Next-state, next-PC and handshake outputs.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch); npc defaults to pc because the PC register
    // has no enable and must reload its own value to hold.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        drain_addr_d = drain_addr_q;
        npc          = pc;
        imem_req     = 1'b0;
        imem_addr    = pc;
        inst_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (redir) begin
                    npc = redir_tgt;
                    if (!imem_ack) begin
                        // Request still pending: remember its address so it
                        // can be completed unchanged and then thrown away.
                        drain_addr_d = pc;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc;
                    npc       = pc + PC_STEP;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (redir) begin
                    npc     = redir_tgt;
                    state_d = WAIT;
                end else if (id_ready) begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (redir) begin
                    npc = redir_tgt;
                end
                if (imem_ack) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst    = inst_q;
    assign inst_pc = inst_pc_q;

endmodule
